// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver and scan-code to ASCII translator.
// Synchronizes and glitch-filters the raw PS/2 pins, assembles 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) and keeps the ASCII code of the
// currently held mapped key on `key`.
// Optional build macro KEY_TYPEMATIC_FILTER_EN: when defined, a repeated make
// of the key already held does not strobe key_valid.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // True when the nine bits (data plus parity) hold an odd number of ones.
    function automatic logic odd_parity(input logic [8:0] v);
        return ^v;
    endfunction

    // Scan code to ASCII; 8'h00 means the code is not mapped.
    function automatic logic [7:0] translate(input logic ext, input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        if (ext) begin
            case (code)
                8'h75:   a = 8'h77;
                8'h6B:   a = 8'h61;
                8'h72:   a = 8'h73;
                8'h74:   a = 8'h64;
                8'h5A:   a = 8'h0D;
                default: a = 8'h00;
            endcase
        end else begin
            case (code)
                8'h76:   a = 8'h1B;
                8'h5A:   a = 8'h0D;
                8'h16:   a = 8'h31;
                8'h1E:   a = 8'h32;
                8'h26:   a = 8'h33;
                8'h25:   a = 8'h34;
                8'h1D:   a = 8'h77;
                8'h1C:   a = 8'h61;
                8'h1B:   a = 8'h73;
                8'h23:   a = 8'h64;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_s;
    logic          data_s;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_vld_q, byte_vld_d;
    logic          err_q, err_d;

    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [7:0]    key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic [7:0]    ascii_s;

    assign data_s    = data_sync_q[1];
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign frame_err = err_q;

    // Two-flop synchronizers for both asynchronous pins; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive opposite samples;
    // the falling edge is flagged in the same cycle the flip is decided.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = {FW{1'b0}};
        fall_s = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
                fall_s = filt_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end else begin
            fcnt_d = {FW{1'b0}};
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b1;
            fcnt_q <= {FW{1'b0}};
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Frame FSM next state: a falling edge always takes priority over timeout.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        tmo_d      = tmo_q;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;
        if (fall_s) begin
            tmo_d = {TW{1'b0}};
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = ST_PARITY;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = odd_parity({data_s, shift_q});
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_s && par_ok_q) begin
                        byte_vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                tmo_d   = {TW{1'b0}};
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = {TW{1'b0}};
        end
    end

    // Frame FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            par_ok_q   <= 1'b0;
            tmo_q      <= {TW{1'b0}};
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            tmo_q      <= tmo_d;
            byte_vld_q <= byte_vld_d;
            err_q      <= err_d;
        end
    end

    // Scan-code layer: prefixes, make/break and key hold. shift_q still holds
    // the accepted byte here because the FSM is back in IDLE.
    always_comb begin
        key_d       = key_q;
        key_valid_d = 1'b0;
        ext_d       = ext_q;
        brk_d       = brk_q;
        ascii_s     = translate(ext_q, shift_q);
        if (byte_vld_q) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (ascii_s != 8'h00) begin
                    if (brk_q) begin
                        if (ascii_s == key_q) begin
                            key_d = 8'h00;
                        end else begin
                            key_d = key_q;
                        end
                    end else begin
                        key_d = ascii_s;
`ifdef KEY_TYPEMATIC_FILTER_EN
                        key_valid_d = (ascii_s != key_q);
`else
                        key_valid_d = 1'b1;
`endif
                    end
                end else begin
                    key_d = key_q;
                end
            end
        end else if (err_q) begin
            // A broken frame or timeout drops any pending prefix.
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else begin
            ext_d = ext_q;
        end
    end

    // Scan-code layer registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_q       <= 8'h00;
            key_valid_q <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

endmodule
